// File: rtl/add_serial_sched.sv
// Round-robin scheduler that time-shares one serial adder among NREQ requesters.
// One transaction in flight: accept, launch pulse, fixed-latency wait, handshaked response.
module add_serial_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ADD_LAT = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]        rsp_sum,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    add_en,
  output logic [WIDTH-1:0]        add_a,
  output logic [WIDTH-1:0]        add_b,
  input  logic [WIDTH-1:0]        add_out
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [IdW-1:0]    ptr_q, ptr_d;
  logic [IdW-1:0]    grant_q, grant_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IdW-1:0]    winner;
  logic              found;
  logic [WIDTH-1:0]  a_arr [NREQ];
  logic [WIDTH-1:0]  b_arr [NREQ];

  function automatic logic [IdW-1:0] wrap_add(input logic [IdW-1:0] base,
                                              input int unsigned off);
    return IdW'((32'(base) + off) % NREQ);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      a_arr[i] = req_a[i*WIDTH +: WIDTH];
      b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end
  end

  // First valid requester at or after ptr_q, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && req_valid[wrap_add(ptr_q, k)]) begin
        found  = 1'b1;
        winner = wrap_add(ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    req_ready = '0;
    rsp_valid = '0;
    add_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          // Keep req_ready low while reset is held, even though the state reads idle.
          req_ready[winner] = rst_n;
          a_d     = a_arr[winner];
          b_d     = b_arr[winner];
          grant_d = winner;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        add_en  = 1'b1;
        cnt_d   = CntW'(ADD_LAT);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == CntW'(1)) begin
          sum_d   = add_out;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        rsp_valid[grant_q] = 1'b1;
        if (rsp_ready[grant_q]) begin
          ptr_d   = wrap_add(grant_q, 1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign grant_id = grant_q;
  assign add_a    = a_q;
  assign add_b    = b_q;
  assign rsp_sum  = sum_q;

endmodule

// File: tb/tb_add_serial_sched.sv
// Self-checking bench for add_serial_sched: transaction-timeline reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_add_serial_sched;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int ADD_LAT = 10;
  localparam int IDW     = $clog2(NREQ);

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_sum;
  logic [NREQ-1:0]       rsp_ready = '0;
  logic                  busy;
  logic [IDW-1:0]        grant_id;
  logic                  add_en;
  logic [WIDTH-1:0]      add_a, add_b, add_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  add_serial_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_ready(rsp_ready),
    .busy(busy), .grant_id(grant_id), .add_en(add_en), .add_a(add_a), .add_b(add_b),
    .add_out(add_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder stand-in: output is wrong until ADD_LAT cycles after the start pulse.
  logic [WIDTH-1:0] ad_a = '0, ad_b = '0;
  int ad_cnt = ADD_LAT;
  always @(posedge clk) begin
    if (add_en) begin
      ad_a <= add_a; ad_b <= add_b; ad_cnt <= 0;
    end else if (ad_cnt < ADD_LAT) begin
      ad_cnt <= ad_cnt + 1;
    end
  end
  assign add_out = (ad_cnt >= ADD_LAT - 1) ? ad_a + ad_b : ~(ad_a + ad_b);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] r;
    r = '0; r[i] = 1'b1;
    return r;
  endfunction

  // Reference model: a transaction is either absent or has an age in cycles since accept.
  bit m_active = 0;
  int m_age = 0, m_grant = 0, m_ptr = 0;
  int m_a = 0, m_b = 0;

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      m_active <= 0; m_ptr <= 0; m_grant <= 0; m_age <= 0;
    end else if (!m_active) begin
      w = rr_pick(req_valid, m_ptr);
      if (w >= 0) begin
        m_active <= 1; m_age <= 1; m_grant <= w;
        m_a <= int'(req_a[w*WIDTH +: WIDTH]);
        m_b <= int'(req_b[w*WIDTH +: WIDTH]);
      end
    end else if (m_age >= ADD_LAT + 2) begin
      if (rsp_ready[m_grant]) begin
        m_active <= 0; m_ptr <= (m_grant + 1) % NREQ;
      end
    end else begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    int w;
    bit in_resp;
    if (chk_on) begin
      w = rr_pick(req_valid, m_ptr);
      in_resp = m_active && (m_age >= ADD_LAT + 2);
      chk("req_ready", req_ready, (rst_n && !m_active && w >= 0) ? onehot(w) : '0);
      chk("busy", busy, m_active);
      chk("add_en", add_en, m_active && (m_age == 1));
      chk("rsp_valid", rsp_valid, in_resp ? onehot(m_grant) : '0);
      chk("grant_id", grant_id, m_grant);
      if (m_active) begin
        chk("add_a", add_a, m_a);
        chk("add_b", add_b, m_b);
      end
      if (in_resp) chk("rsp_sum", rsp_sum, (m_a + m_b) % (1 << WIDTH));
      if (!rst_n) begin
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
      end
    end
  end

  task automatic set_ops(input int who, input int a, input int b);
    req_a[who*WIDTH +: WIDTH] = WIDTH'(a);
    req_b[who*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  task automatic do_reset();
    req_valid = '0; rsp_ready = '0;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Returns just after the accept edge; g = granted index, t = cycle of the accept.
  task automatic next_grant(output int g, output int t);
    g = -1; t = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
        t = cyc;
        break;
      end
    end
    if (g < 0) chk("grant_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp(output logic [WIDTH-1:0] s, output int t);
    s = '0; t = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin s = rsp_sum; t = cyc; break; end
    end
    if (t < 0) chk("rsp_timeout", 0, 1);
  endtask

  task automatic txn(input int who, input int a, input int b, input int exp_sum, input string nm);
    int g, t0, t1;
    logic [WIDTH-1:0] s;
    set_ops(who, a, b);
    req_valid = onehot(who);
    next_grant(g, t0);
    req_valid = '0;
    chk({nm, "_grant"}, g, who);
    wait_rsp(s, t1);
    chk({nm, "_sum"}, s, exp_sum);
    @(posedge clk); #1;
  endtask

  initial begin
    int g, t0, t1, tp;
    int exp3 [5] = '{0, 1, 2, 3, 0};
    int exp4 [4] = '{1, 3, 1, 3};
    logic [WIDTH-1:0] s;

    #1 rst_n = 1'b0;
    chk_on = 1'b1;
    req_valid = '1;
    #2 chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    req_valid = '0;
    #1 rst_n = 1'b1;

    // Single request, exact latency.
    set_ops(0, 3, 5); req_valid = 4'b0001; rsp_ready = 4'b0001;
    next_grant(g, t0);
    chk("t1_grant", g, 0);
    req_valid = '0;
    @(negedge clk); chk("t1_add_en", add_en, 1);
    wait_rsp(s, t1);
    chk("t1_sum", s, 8);
    chk("t1_latency", t1 - t0, ADD_LAT + 2);
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    @(posedge clk); #1;

    // Modulo arithmetic.
    rsp_ready = '1;
    txn(2, 200, 100, 44, "t2a");
    txn(1, 255, 1, 0, "t2b");

    // All requesting: strict rotation with wrap.
    do_reset();
    req_valid = '1; rsp_ready = '1;
    tp = 0;
    for (int i = 0; i < 5; i++) begin
      next_grant(g, t0);
      chk("t3_grant", g, exp3[i]);
      if (i > 0) chk("t3_spacing", t0 - tp, ADD_LAT + 3);
      tp = t0;
    end

    // Sparse requesters, then a newcomer at index 0.
    do_reset();
    req_valid = 4'b1010; rsp_ready = '1;
    for (int i = 0; i < 4; i++) begin
      next_grant(g, t0);
      chk("t4_grant", g, exp4[i]);
    end
    req_valid = 4'b1011;
    next_grant(g, t0);
    chk("t4_wrap_grant", g, 0);

    // Response back-pressure; other requesters' rsp_ready must be ignored.
    do_reset();
    set_ops(0, 7, 9);
    req_valid = '1; rsp_ready = 4'b1110;
    next_grant(g, t0);
    chk("t5_grant", g, 0);
    wait_rsp(s, t1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("t5_hold_valid", rsp_valid, 4'b0001);
      chk("t5_hold_sum", rsp_sum, 16);
      chk("t5_hold_ready", req_ready, 0);
      chk("t5_hold_add_en", add_en, 0);
    end
    @(posedge clk); #1 rsp_ready = '1;
    @(negedge clk); chk("t5_release_valid", rsp_valid, 4'b0001);
    @(negedge clk); chk("t5_idle_busy", busy, 0);
    chk("t5_idle_ready", req_ready, 4'b0010);
    @(posedge clk); #1;

    // Reset in the middle of a wait.
    do_reset();
    rsp_ready = '1;
    txn(2, 1, 2, 3, "t6a");
    set_ops(2, 4, 4); req_valid = 4'b0100; rsp_ready = '0;
    next_grant(g, t0);
    req_valid = '0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("t6_busy", busy, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_add_en", add_en, 0);
    chk("t6_add_a", add_a, 0);
    chk("t6_add_b", add_b, 0);
    chk("t6_grant_id", grant_id, 0);
    chk("t6_rsp_sum", rsp_sum, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    rsp_ready = '1;
    repeat (ADD_LAT + 4) begin
      @(negedge clk); chk("t6_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1 req_valid = 4'b1110;
    next_grant(g, t0);
    chk("t6_first_grant", g, 1);
    req_valid = '0;

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      req_valid = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) set_ops(i, int'($urandom_range(0, 255)),
                                            int'($urandom_range(0, 255)));
      rsp_ready = NREQ'($urandom);
    end

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
